// File: rtl/sdrc_bank_arb.sv
// sdrc_bank_arb: picks one of four bank requests per cycle and forwards it to the transfer controller.
// Ports: clk/reset_n (sync, active-low); bk_* per-bank request bundles in, bk_ack per-bank accept out;
// b2x_* granted command to xfr_ctl, x2b_ack accept from xfr_ctl; arb_locked burst-lock status.
module sdrc_bank_arb #(
  parameter int REQ_BW   = 12,
  parameter int ID_W     = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          bk_req,
  input  logic [7:0]          bk_cmd,
  input  logic [51:0]         bk_addr,
  input  logic [4*ID_W-1:0]   bk_id,
  input  logic [4*REQ_BW-1:0] bk_len,
  input  logic [3:0]          bk_start,
  input  logic [3:0]          bk_last,
  input  logic [3:0]          bk_wrap,
  output logic [3:0]          bk_ack,
  output logic                b2x_req,
  output logic [1:0]          b2x_ba,
  output logic [1:0]          b2x_cmd,
  output logic [12:0]         b2x_addr,
  output logic [ID_W-1:0]     b2x_id,
  output logic [REQ_BW-1:0]   b2x_len,
  output logic                b2x_start,
  output logic                b2x_last,
  output logic                b2x_wrap,
  input  logic                x2b_ack,
  output logic                arb_locked
);
  logic [1:0] rr_q, rr_d, lock_ba_q, lock_ba_d, gnt;
  logic       lock_vld_q, lock_vld_d, acc;
  logic [3:0] starve_q [4];
  logic [3:0] starve_d [4];
  logic [3:0] data, urgent, cand;
  // cmd[1] set means RD/WR; urgent row-class banks override the data-class preference
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      data[i]   = bk_cmd[2*i+1];
      urgent[i] = bk_req[i] & ~data[i] & (starve_q[i] == 4'(MAX_WAIT));
    end
    cand = lock_vld_q       ? (bk_req & (4'b1 << lock_ba_q)) :
           |urgent          ? urgent :
           |(bk_req & data) ? (bk_req & data) : bk_req;
    // descending scan so the candidate closest to rr_q is assigned last
    gnt = rr_q;
    for (int k = 3; k >= 0; k--)
      if (cand[rr_q + 2'(k)]) gnt = rr_q + 2'(k);
  end
  assign b2x_req    = reset_n & |cand;
  assign acc        = b2x_req & x2b_ack;
  assign bk_ack     = acc ? (4'b1 << gnt) : 4'b0;
  assign b2x_ba     = gnt;
  assign b2x_cmd    = bk_cmd[2*gnt +: 2];
  assign b2x_addr   = bk_addr[13*gnt +: 13];
  assign b2x_id     = bk_id[ID_W*gnt +: ID_W];
  assign b2x_len    = bk_len[REQ_BW*gnt +: REQ_BW];
  assign b2x_start  = bk_start[gnt];
  assign b2x_last   = bk_last[gnt];
  assign b2x_wrap   = bk_wrap[gnt];
  assign arb_locked = reset_n & lock_vld_q;
  always_comb begin
    rr_d       = acc ? gnt + 2'd1 : rr_q;
    lock_vld_d = lock_vld_q;
    lock_ba_d  = lock_ba_q;
    // only data-class accepts touch the lock; row-class from the locked bank leaves it alone
    if (acc && data[gnt]) begin
      if (!bk_last[gnt]) begin
        lock_vld_d = 1'b1;
        lock_ba_d  = gnt;
      end else if (gnt == lock_ba_q) lock_vld_d = 1'b0;
    end
    for (int i = 0; i < 4; i++)
      starve_d[i] = (!bk_req[i] || data[i] || bk_ack[i]) ? 4'd0 :
                    (starve_q[i] == 4'(MAX_WAIT))         ? starve_q[i] : starve_q[i] + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q       <= 2'd0;
      lock_vld_q <= 1'b0;
      lock_ba_q  <= 2'd0;
      for (int i = 0; i < 4; i++) starve_q[i] <= 4'd0;
    end else begin
      rr_q       <= rr_d;
      lock_vld_q <= lock_vld_d;
      lock_ba_q  <= lock_ba_d;
      starve_q   <= starve_d;
    end
  end
endmodule

// File: tb/tb_sdrc_bank_arb.sv
// tb_sdrc_bank_arb: directed scoreboard bench for sdrc_bank_arb.
module tb_sdrc_bank_arb;
  localparam int RB = 12, IW = 4;
  localparam logic [1:0] PRE = 2'b00, ACT = 2'b01, RD = 2'b10, WR = 2'b11;
  logic clk = 1'b0, reset_n = 1'b0, x2b_ack = 1'b0;
  logic [3:0] bk_req = '0, bk_start = '0, bk_last = '0, bk_wrap = '0, bk_ack;
  logic [7:0] bk_cmd = '0;
  logic [51:0] bk_addr = {13'h0A3, 13'h0A2, 13'h0A1, 13'h0A0};
  logic [4*IW-1:0] bk_id = {4'd8, 4'd7, 4'd6, 4'd5};
  logic [4*RB-1:0] bk_len = {12'h103, 12'h102, 12'h101, 12'h100};
  logic b2x_req, b2x_start, b2x_last, b2x_wrap, arb_locked;
  logic [1:0] b2x_ba, b2x_cmd;
  logic [12:0] b2x_addr;
  logic [IW-1:0] b2x_id;
  logic [RB-1:0] b2x_len;
  typedef struct {logic req; logic [1:0] ba; logic [1:0] cmd; logic [3:0] ack; logic lock;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  sdrc_bank_arb #(.REQ_BW(RB), .ID_W(IW), .MAX_WAIT(8)) dut (
    .clk(clk), .reset_n(reset_n), .bk_req(bk_req), .bk_cmd(bk_cmd), .bk_addr(bk_addr),
    .bk_id(bk_id), .bk_len(bk_len), .bk_start(bk_start), .bk_last(bk_last), .bk_wrap(bk_wrap),
    .bk_ack(bk_ack), .b2x_req(b2x_req), .b2x_ba(b2x_ba), .b2x_cmd(b2x_cmd), .b2x_addr(b2x_addr),
    .b2x_id(b2x_id), .b2x_len(b2x_len), .b2x_start(b2x_start), .b2x_last(b2x_last),
    .b2x_wrap(b2x_wrap), .x2b_ack(x2b_ack), .arb_locked(arb_locked));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic setb(input int i, input logic r, input logic [1:0] c, input logic l);
    bk_req[i] = r;
    bk_cmd[2*i +: 2] = c;
    bk_last[i] = l;
  endtask
  // push the expectation for the current inputs, compare mid-cycle, then advance past the edge
  task automatic step(input logic req, input logic [1:0] ba, input logic [1:0] cmd, input logic lock);
    exp_t e, o;
    e.req = req; e.ba = ba; e.cmd = cmd; e.lock = lock;
    e.ack = (req && x2b_ack) ? (4'b1 << ba) : 4'b0;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    chk("b2x_req", 32'(b2x_req), 32'(o.req));
    chk("bk_ack", 32'(bk_ack), 32'(o.ack));
    chk("arb_locked", 32'(arb_locked), 32'(o.lock));
    if (o.req) begin
      chk("b2x_ba", 32'(b2x_ba), 32'(o.ba));
      chk("b2x_cmd", 32'(b2x_cmd), 32'(o.cmd));
      chk("b2x_addr", 32'(b2x_addr), 32'(13'h0A0 + 13'(o.ba)));
      chk("b2x_id", 32'(b2x_id), 32'(4'd5 + 4'(o.ba)));
      chk("b2x_len", 32'(b2x_len), 32'(12'h100 + 12'(o.ba)));
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    // reset with all banks requesting and ack high: nothing may leak out
    for (int i = 0; i < 4; i++) setb(i, 1'b1, RD, 1'b1);
    x2b_ack = 1'b1;
    step(0, 0, RD, 0);
    step(0, 0, RD, 0);
    reset_n = 1'b1;
    // all RD: strict rotation 0,1,2,3,0
    step(1, 0, RD, 0);
    step(1, 1, RD, 0);
    step(1, 2, RD, 0);
    step(1, 3, RD, 0);
    step(1, 0, RD, 0);
    bk_req = '0;
    step(0, 0, RD, 0);
    // bank1 PRE vs bank2 WR: data class first (rr=1)
    setb(1, 1'b1, PRE, 1'b1);
    setb(2, 1'b1, WR, 1'b1);
    step(1, 2, WR, 0);
    setb(2, 1'b0, WR, 1'b1);
    step(1, 1, PRE, 0);
    bk_req = '0;
    // bank0 RD stream vs bank3 ACT: promotion on the 9th cycle, then counter cleared
    setb(0, 1'b1, RD, 1'b1);
    setb(3, 1'b1, ACT, 1'b1);
    for (int c = 0; c < 8; c++) step(1, 0, RD, 0);
    step(1, 3, ACT, 0);
    step(1, 0, RD, 0);
    bk_req = '0;
    // burst lock on bank2 with bank0 WR waiting (rr=1)
    setb(2, 1'b1, RD, 1'b0);
    setb(0, 1'b1, WR, 1'b1);
    bk_start[2] = 1'b1;
    step(1, 2, RD, 0);
    bk_start[2] = 1'b0;
    step(1, 2, RD, 1);
    setb(2, 1'b0, RD, 1'b0);
    step(0, 0, RD, 1);
    setb(2, 1'b1, ACT, 1'b0);
    step(1, 2, ACT, 1);
    setb(2, 1'b1, RD, 1'b1);
    step(1, 2, RD, 1);
    setb(2, 1'b0, RD, 1'b1);
    step(1, 0, WR, 0);
    bk_req = '0;
    // no ack: grant held, rr unchanged (rr=1)
    x2b_ack = 1'b0;
    setb(0, 1'b1, RD, 1'b1);
    setb(1, 1'b1, RD, 1'b1);
    for (int c = 0; c < 5; c++) step(1, 1, RD, 0);
    x2b_ack = 1'b1;
    step(1, 1, RD, 0);
    step(1, 0, RD, 0);
    bk_req = '0;
    // lock on bank0 while bank1 PRE starves to 5, then reset mid-lock
    setb(0, 1'b1, WR, 1'b0);
    setb(1, 1'b1, PRE, 1'b1);
    step(1, 0, WR, 0);
    setb(0, 1'b1, RD, 1'b0);
    for (int c = 0; c < 4; c++) step(1, 0, RD, 1);
    reset_n = 1'b0;
    step(0, 0, RD, 0);
    reset_n = 1'b1;
    // post-reset: scan restarts at bank0, lock and starvation gone
    setb(0, 1'b1, RD, 1'b1);
    setb(2, 1'b1, RD, 1'b1);
    step(1, 0, RD, 0);
    step(1, 2, RD, 0);
    step(1, 0, RD, 0);
    step(1, 2, RD, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
